// File: rtl/game_sequencer_if.sv
// Sequencer-facing signal bundle: button/collision status in, control strobes and status out.
interface game_sequencer_if;
  logic       start;
  logic       pause;
  logic       frame_tick;
  logic       wall_col;
  logic       pad_col;
  logic       lossA;
  logic       lossB;
  logic       game_en;
  logic       col_rst_n;
  logic       gmv;
  logic [2:0] state;
  logic [1:0] loser;
  logic       beep;

  modport master (
    output start, pause, frame_tick, wall_col, pad_col, lossA, lossB,
    input  game_en, col_rst_n, gmv, state, loser, beep
  );

  modport slave (
    input  start, pause, frame_tick, wall_col, pad_col, lossA, lossB,
    output game_en, col_rst_n, gmv, state, loser, beep
  );
endinterface

// File: rtl/game_sequencer.sv
// Game flow sequencer: serve/play/point/pause/over state machine, frame-based holds and beep timer.
//
// state | meaning
// IDLE  | scores cleared, waiting for start
// SERVE | ball held at centre for SERVE_FRAMES
// PLAY  | rally in progress
// POINT | frozen for POINT_FRAMES after a wall hit
// PAUSE | frozen until pause pressed again
// OVER  | game finished, loser latched
module game_sequencer #(
  parameter logic [7:0]  SERVE_FRAMES = 8'd60,
  parameter logic [7:0]  POINT_FRAMES = 8'd30,
  parameter logic [23:0] BEEP_CYCLES  = 24'd2500000
) (
  input logic              clk,
  input logic              rst,
  game_sequencer_if.slave  gs
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t      st;
  logic [7:0]  frm_cnt;
  logic [23:0] beep_cnt;
  logic [1:0]  loser_q;
  logic        start_q;
  logic        pause_q;
  logic        start_rise;
  logic        pause_rise;
  logic        frm_done;

  assign start_rise = gs.start & ~start_q;
  assign pause_rise = gs.pause & ~pause_q;
  // Expiry on 1 or 0 so a zero-length hold still exits on the first tick.
  assign frm_done   = gs.frame_tick & (frm_cnt <= 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      frm_cnt  <= 8'd0;
      beep_cnt <= 24'd0;
      loser_q  <= 2'b00;
      start_q  <= 1'b1;
      pause_q  <= 1'b1;
    end else begin
      start_q <= gs.start;
      pause_q <= gs.pause;

      if (st == PLAY && (gs.pad_col || gs.wall_col))
        beep_cnt <= BEEP_CYCLES;
      else if (beep_cnt != 24'd0)
        beep_cnt <= beep_cnt - 24'd1;

      if (gs.frame_tick && frm_cnt != 8'd0)
        frm_cnt <= frm_cnt - 8'd1;

      case (st)
        IDLE: begin
          if (start_rise) begin
            st      <= SERVE;
            frm_cnt <= SERVE_FRAMES;
          end
        end
        SERVE: begin
          if (frm_done)
            st <= PLAY;
        end
        PLAY: begin
          if (gs.wall_col) begin
            if (gs.lossA || gs.lossB) begin
              st      <= OVER;
              loser_q <= {gs.lossB, gs.lossA};
            end else begin
              st      <= POINT;
              frm_cnt <= POINT_FRAMES;
            end
          end else if (pause_rise) begin
            st <= PAUSE;
          end
        end
        POINT: begin
          if (frm_done) begin
            st      <= SERVE;
            frm_cnt <= SERVE_FRAMES;
          end
        end
        PAUSE: begin
          if (pause_rise)
            st <= PLAY;
        end
        OVER: begin
          if (start_rise)
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign gs.state     = st;
  assign gs.loser     = loser_q;
  assign gs.beep      = (beep_cnt != 24'd0);
  assign gs.col_rst_n = ~((st == IDLE) || (st == SERVE));
  assign gs.gmv       = (st == IDLE);
  assign gs.game_en   = gs.frame_tick & ((st == IDLE) || (st == SERVE) || (st == PLAY));

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter SERVE_FRAMES, 8'd60: number of frame ticks the ball is held at centre before play.
REQ-002 Parameter POINT_FRAMES, 8'd30: number of frame ticks the game is frozen after a point.
REQ-003 Parameter BEEP_CYCLES, 24'd2500000: length of the beep pulse in clk cycles.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  start/restart button, level, already synchronised to clk.
REQ-007 pause  in  1  pause button, level, already synchronised to clk.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 wall_col, pad_col, lossA, lossB  in  1 each  status from the collision controller.
REQ-010 game_en  out  1  collision-controller update strobe.
REQ-011 col_rst_n  out  1  collision-controller reset, active-low.
REQ-012 gmv  out  1  score-clear request to the collision controller.
REQ-013 state  out  3  current state code: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5.
REQ-014 loser  out  2  latched {lossB, lossA} at game over.
REQ-015 beep  out  1  sound enable.

Function
REQ-016 Edge detection: start_rise and pause_rise are each high for one cycle when the input was 0 in the previous cycle and is 1 in this cycle.
REQ-017 col_rst_n shall be 0 in IDLE and SERVE, and 1 in all other states.
REQ-018 gmv shall be 1 in IDLE only.
REQ-019 game_en shall equal frame_tick in IDLE, SERVE and PLAY, and shall be 0 in POINT, PAUSE and OVER.
- game_en is combinational from state and frame_tick, with zero latency.
REQ-020 IDLE: on start_rise, go to SERVE and load frm_cnt with SERVE_FRAMES.
REQ-021 SERVE: on each frame_tick, decrement frm_cnt.
- When frame_tick occurs with frm_cnt==1, or with frm_cnt==0, go to PLAY.
- SERVE_FRAMES=0 is therefore exited on the first frame_tick.
REQ-022 PLAY, when wall_col=1:
- if lossA or lossB is 1, go to OVER and latch loser<={lossB,lossA};
- otherwise go to POINT and load frm_cnt with POINT_FRAMES.
REQ-023 PLAY, pause_rise with wall_col=0: go to PAUSE.
- wall_col has priority over pause_rise in the same cycle.
REQ-024 PAUSE: on pause_rise, return to PLAY; all other inputs are ignored.
REQ-025 POINT: count frame ticks as in SERVE.
- On expiry, go to SERVE and load frm_cnt with SERVE_FRAMES.
REQ-026 OVER: on start_rise, go to IDLE.
- loser holds its value until the next entry to OVER or until rst.
REQ-027 start_rise is ignored in SERVE, PLAY, POINT and PAUSE.
REQ-028 frm_cnt is 8 bits, decrements only on frame_tick, and never wraps below 0.
REQ-029 beep counter (24 bits): in PLAY, when pad_col or wall_col is 1, load BEEP_CYCLES; this reload retriggers the count.
- Otherwise decrement while nonzero.
- beep = (counter != 0).
- beep keeps counting down in every state.
REQ-030 Unused state encodings (6, 7) shall transition to IDLE on the next clock.

Reset
REQ-031 When rst=1 at a clock edge, the next state values are:
- state=IDLE, frm_cnt=0, beep counter=0, loser=2'b00, edge-detect registers=1.
- The edge registers are set to 1 so that a button held through reset does not generate an edge.
REQ-032 Reset values of the outputs follow from REQ-031:
- col_rst_n=0, gmv=1, beep=0, loser=0, state=0.
- game_en equals frame_tick.
REQ-033 rst has priority over every other input, including during SERVE or POINT counting.

Verification
REQ-034 Release rst; pulse start; apply frame_tick every 10 cycles with SERVE_FRAMES=3.
- Required: state goes 0->1.
- On the 3rd frame_tick the state goes to 2 (PLAY), and col_rst_n rises in the next cycle.
REQ-035 In PLAY, pulse wall_col=1 with lossA=0 and lossB=0, with POINT_FRAMES=2.
- Required: state=3 and game_en stays 0 through 2 frame ticks.
- Then state=1 (SERVE) with col_rst_n=0.
REQ-036 In PLAY, pulse wall_col=1 with lossB=1.
- Required: state=5, loser=2'b10, game_en=0.
- Then a start pulse gives state=0 and gmv=1.
REQ-037 In PLAY, assert pause_rise and wall_col in the same cycle with no loss flag.
- Required: state=3 (POINT), not PAUSE.
- Separately: pause toggles 2->4->2, and game_en=0 while in PAUSE.
REQ-038 pad_col pulse in PLAY with BEEP_CYCLES=5.
- Required: beep=1 for exactly 5 cycles.
- A second pad_col pulse 3 cycles later extends beep to 5 cycles from the retrigger.
REQ-039 Assert rst during SERVE with start held high.
- Required: state=0, frm_cnt=0.
- No start edge after rst is released, until start goes low and then high again.
